dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single-port 32-bit data memory RAM between the processor datapath (port A) and a loader/debug master (port B). It issues at most one access per cycle to the RAM, applies round-robin fairness with an optional atomic lock, and returns read data with the RAM's fixed one-cycle latency. The block sits between both masters and the data memory RAM primitive, and drives the RAM's clock-enabled write and address inputs directly.

## Interface
- ADDR_WIDTH, 32, width of the address passed to the RAM
- DATA_WIDTH, 32, width of the read and write data
- CNT_WIDTH, 16, width of the saturating conflict counter
- clk  in  1  system clock; every register is clocked on the rising edge
- rst  in  1  asynchronous, active-high reset
- a_req / b_req  in  1  access request; held high until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_lock / b_lock  in  1  while high and owned, the port keeps ownership
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_gnt / b_gnt  out  1  combinational; the access is issued this cycle
- a_rvalid / b_rvalid  out  1  read data valid; registered
- a_rdata / b_rdata  out  DATA_WIDTH  equals ram_dout, qualified by rvalid
- ram_we  out  4  all four bits equal the write strobe of the granted access
- ram_addr  out  ADDR_WIDTH  address of the granted port, else 0
- ram_din  out  DATA_WIDTH  write data of the granted port, else 0
- ram_dout  in  DATA_WIDTH  RAM read data, valid one cycle after the address
- conflict_cnt  out  CNT_WIDTH  count of cycles with a_req && b_req; saturates

## Operation
- Owner state machine with three states: FREE, OWN_A, OWN_B. Reset value is FREE.
- FREE:
  - If only one port requests, that port is granted.
  - If both request, the port that is not `last` is granted.
  - `last` is a 1-bit register holding the last granted port; its reset value is B, so A wins the first tie.
- Lock entry: a grant to port X with x_lock=1 moves the state to OWN_X.
- OWN_X:
  - Only X can be granted; the other port's gnt stays 0 even if it requests.
  - Leave to FREE on the first cycle x_lock=0, evaluated before arbitration.
  - In that same cycle, arbitration proceeds as in FREE.
- Each grant updates `last` to the granted port.
- At most one gnt is high in any cycle. gnt=1 requires req=1.
- Write access: ram_we=4'b1111 in the grant cycle. No rvalid is produced.
- Read access: ram_we=0. A pending register records {valid, owner}. The next cycle asserts owner_rvalid=1 for one cycle, with rdata = ram_dout.
- Back-to-back reads are allowed. Pipelining reads across the two ports in consecutive cycles is allowed; each rvalid goes only to its own owner.
- The non-owner's rdata also shows ram_dout, but its rvalid stays 0.
- Requester rule: after a grant, the requester may drop or change req/addr in the next cycle.
- conflict_cnt increments every cycle both req are high, regardless of lock. It holds at all-ones.

## Timing
- Grant and RAM drive: combinational from req, lock and state in cycle N. The access is sampled by the RAM at the edge ending cycle N.
- Read latency: rvalid and rdata appear in cycle N+1, exactly one cycle after gnt.
- Throughput: one access per cycle.
- Worst-case wait without locks: one cycle. A locked owner can starve the other port indefinitely; this is by design.
- Reset values: state=FREE, last=B, rvalid(a,b)=0, pending=0, conflict_cnt=0. All gnt, ram_we, ram_addr and ram_din are 0 while rst=1.
- Reset asserted mid-read: the pending read is dropped, so no rvalid appears after reset releases.
- Reset asserted while locked: the state returns to FREE.
- No request in a cycle: ram_we=0, so the RAM contents are unchanged.

## Test plan
- Single read: A reads addr 0x10 holding 0xDEADBEEF. Expect a_gnt in cycle N; a_rvalid=1 with a_rdata=0xDEADBEEF in N+1; b_rvalid=0 throughout.
- Simultaneous requests right after reset: A and B both write. Expect A granted first, then B in the next cycle. Reading back addr 0x4 returns B's data 0x22222222 when both targeted 0x4.
- Round-robin: both ports hold read requests for 6 cycles. Expect grants alternating A,B,A,B,A,B, each port's rvalid one cycle after its gnt, and conflict_cnt advancing accordingly.
- Lock: B asserts lock for a read-modify-write on 0x8 (read 5, write 6) while A requests continuously. Expect a_gnt=0 until b_lock drops, then A is granted in that same cycle and A's read returns 6.
- Reset mid-read: assert rst in the cycle after a_gnt for a read. Expect a_rvalid=0 after release, and all outputs at their reset values while rst=1.
- Counter saturation: with CNT_WIDTH=4, hold both req for 20 cycles. Expect conflict_cnt to stop at 15.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Per-master data memory port: request side driven by the master,
// grant and read return driven by the arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory RAM.
// Round-robin between ports A and B, with an optional lock that lets the
// current owner keep the RAM across cycles. Read data returns one cycle
// after the grant, straight from the RAM output.
//
// state  | meaning
// FREE   | no owner, round-robin arbitration
// OWN_A  | A holds the lock, only A may be granted
// OWN_B  | B holds the lock, only B may be granted
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         a,
    dmem_arbiter_if.slave         b,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {FREE, OWN_A, OWN_B} state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   arb_free;
    logic   gnt_a, gnt_b;
    logic   pend_valid;
    logic   pend_owner;

    // Owner state and last-granted port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FREE;
            last  <= PORT_B;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Arbitration: a dropped lock frees the port in the same cycle it is seen
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        case (state)
            OWN_A:   arb_free = !a.lock;
            OWN_B:   arb_free = !b.lock;
            default: arb_free = 1'b1;
        endcase
        if (!rst) begin
            if (arb_free) begin
                if (a.req && b.req) begin
                    gnt_a = (last == PORT_B);
                    gnt_b = (last == PORT_A);
                end else begin
                    gnt_a = a.req;
                    gnt_b = b.req;
                end
            end else if (state == OWN_A) begin
                gnt_a = a.req;
            end else begin
                gnt_b = b.req;
            end
        end
        if (arb_free) begin
            state_nxt = FREE;
        end
        if (gnt_a) begin
            last_nxt = PORT_A;
            if (a.lock) begin
                state_nxt = OWN_A;
            end
        end
        if (gnt_b) begin
            last_nxt = PORT_B;
            if (b.lock) begin
                state_nxt = OWN_B;
            end
        end
    end

    assign a.gnt    = gnt_a;
    assign b.gnt    = gnt_b;
    assign ram_we   = {4{(gnt_a && a.we) || (gnt_b && b.we)}};
    assign ram_addr = gnt_a ? a.addr  : (gnt_b ? b.addr  : '0);
    assign ram_din  = gnt_a ? a.wdata : (gnt_b ? b.wdata : '0);

    // Pending read: remembers which port's read the RAM is returning next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_owner <= PORT_A;
        end else begin
            pend_valid <= (gnt_a && !a.we) || (gnt_b && !b.we);
            pend_owner <= gnt_b ? PORT_B : PORT_A;
        end
    end

    assign a.rvalid = pend_valid && (pend_owner == PORT_A);
    assign b.rvalid = pend_valid && (pend_owner == PORT_B);
    assign a.rdata  = ram_dout;
    assign b.rdata  = ram_dout;

    // Saturating count of cycles in which both ports request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (a.req && b.req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle requests with hand-derived
// grants, a behavioural RAM, and per-port queues of expected read data.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [3:0]  conflict_cnt;

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (ifa),
        .b            (ifb),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    // Behavioural single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we == 4'hF) mem[ram_addr[7:0]] <= ram_din;
        ram_dout <= mem[ram_addr[7:0]];
    end

    typedef struct {
        logic        rst_before;
        logic        a_req, a_we, a_lock;
        logic [31:0] a_addr, a_wdata;
        logic        b_req, b_we, b_lock;
        logic [31:0] b_addr, b_wdata;
        logic        ea, eb;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        exp_rva, exp_rvb;
    int          cnt_exp;
    int          n_checks, n_err;

    function automatic vec_t mk(logic rb,
                                logic ar, logic aw, logic al, logic [31:0] aa, logic [31:0] ad,
                                logic br, logic bw, logic bl, logic [31:0] ba, logic [31:0] bd,
                                logic ea, logic eb);
        vec_t v;
        v.rst_before = rb;
        v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
        v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        ifa.req = 0; ifa.we = 0; ifa.lock = 0; ifa.addr = 0; ifa.wdata = 0;
        ifb.req = 0; ifb.we = 0; ifb.lock = 0; ifb.addr = 0; ifb.wdata = 0;
    endtask

    task automatic clear_model();
        qa.delete();
        qb.delete();
        exp_rva = 0;
        exp_rvb = 0;
        cnt_exp = 0;
    endtask

    // While rst is high, requests must not reach the RAM
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_gnt"},    32'(ifa.gnt), 0);
        chk({tag, "_b_gnt"},    32'(ifb.gnt), 0);
        chk({tag, "_ram_we"},   32'(ram_we), 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_din"},  ram_din, 0);
        chk({tag, "_a_rvalid"}, 32'(ifa.rvalid), 0);
        chk({tag, "_b_rvalid"}, 32'(ifb.rvalid), 0);
        chk({tag, "_cnt"},      32'(conflict_cnt), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        ifa.req = 1; ifa.we = 1; ifa.addr = 32'h20; ifa.wdata = 32'hBAD0BAD0;
        ifb.req = 1; ifb.we = 1; ifb.addr = 32'h21; ifb.wdata = 32'hBAD1BAD1;
        #2;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        drive_idle();
        rst = 0;
        clear_model();
    endtask

    // One cycle: drive at posedge+1, check at negedge, update the model
    task automatic step(input vec_t v);
        logic [31:0] e;
        logic [31:0] exp_addr, exp_din;
        logic        exp_w;
        ifa.req = v.a_req; ifa.we = v.a_we; ifa.lock = v.a_lock; ifa.addr = v.a_addr; ifa.wdata = v.a_wdata;
        ifb.req = v.b_req; ifb.we = v.b_we; ifb.lock = v.b_lock; ifb.addr = v.b_addr; ifb.wdata = v.b_wdata;
        exp_addr = v.ea ? v.a_addr  : (v.eb ? v.b_addr  : 32'h0);
        exp_din  = v.ea ? v.a_wdata : (v.eb ? v.b_wdata : 32'h0);
        exp_w    = (v.ea && v.a_we) || (v.eb && v.b_we);
        @(negedge clk);
        chk("a_gnt",    32'(ifa.gnt), 32'(v.ea));
        chk("b_gnt",    32'(ifb.gnt), 32'(v.eb));
        chk("ram_we",   32'(ram_we), exp_w ? 32'hF : 32'h0);
        chk("ram_addr", ram_addr, exp_addr);
        chk("ram_din",  ram_din, exp_din);
        chk("a_rvalid", 32'(ifa.rvalid), 32'(exp_rva));
        chk("b_rvalid", 32'(ifb.rvalid), 32'(exp_rvb));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt_exp));
        if (ifa.rvalid) begin
            if (qa.size() == 0) chk("a_rdata_unexpected", 32'(ifa.rvalid), 0);
            else begin e = qa.pop_front(); chk("a_rdata", ifa.rdata, e); end
        end
        if (ifb.rvalid) begin
            if (qb.size() == 0) chk("b_rdata_unexpected", 32'(ifb.rvalid), 0);
            else begin e = qb.pop_front(); chk("b_rdata", ifb.rdata, e); end
        end
        exp_rva = v.ea && !v.a_we;
        exp_rvb = v.eb && !v.b_we;
        if (exp_rva) qa.push_back(ref_mem[v.a_addr[7:0]]);
        if (exp_rvb) qb.push_back(ref_mem[v.b_addr[7:0]]);
        if (exp_w) ref_mem[exp_addr[7:0]] = exp_din;
        if (v.a_req && v.b_req && cnt_exp < 15) cnt_exp++;
        @(posedge clk); #1;
    endtask

    vec_t idle;

    initial begin
        n_checks = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        mem[8]  = 32'd5;        ref_mem[8]  = 32'd5;
        rst = 1;
        drive_idle();
        clear_model();
        idle = mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0);

        // Single read of 0x10 by A
        tbl.push_back(mk(1, 1,0,0,32'h10,0,            0,0,0,0,0,                    1,0));
        tbl.push_back(idle);
        // Simultaneous writes to 0x4 right after reset: A first, then B
        tbl.push_back(mk(1, 1,1,0,32'h4,32'h11111111,  1,1,0,32'h4,32'h22222222,     1,0));
        tbl.push_back(mk(0, 0,0,0,0,0,                 1,1,0,32'h4,32'h22222222,     0,1));
        tbl.push_back(mk(0, 1,0,0,32'h4,0,             0,0,0,0,0,                    1,0));
        tbl.push_back(idle);
        // Round-robin: both read for six cycles
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(i == 0, 1,0,0,32'h10,0,   1,0,0,32'h4,0,   (i % 2) == 0, (i % 2) == 1));
        tbl.push_back(idle);
        // Locked read-modify-write by B on 0x8 while A keeps requesting
        tbl.push_back(mk(0, 0,0,0,0,0,                 1,0,1,32'h8,0,                0,1));
        tbl.push_back(mk(0, 1,0,0,32'h8,0,             1,1,1,32'h8,32'd6,            0,1));
        tbl.push_back(mk(0, 1,0,0,32'h8,0,             0,0,1,0,0,                    0,0));
        tbl.push_back(mk(0, 1,0,0,32'h8,0,             0,0,0,0,0,                    1,0));
        tbl.push_back(idle);

        #3;
        check_reset_outputs("init");
        @(posedge clk); #1;
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            step(tbl[i]);
        end

        // Saturation: both read for 20 cycles, B first since A was granted last
        for (int i = 0; i < 20; i++)
            step(mk(0, 1,0,0,32'h10,0, 1,0,0,32'h4,0, (i % 2) == 1, (i % 2) == 0));
        step(idle);
        chk("cnt_saturated", 32'(conflict_cnt), 32'd15);

        // Reset during a pending read drops the read
        step(mk(0, 1,0,0,32'h10,0, 0,0,0,0,0, 1,0));
        rst = 1;
        ifa.req = 1; ifb.req = 1;
        #2;
        check_reset_outputs("midrd");
        @(posedge clk); #1;
        check_reset_outputs("midrd2");
        drive_idle();
        rst = 0;
        clear_model();
        step(idle);
        step(idle);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
